// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM state type, default geometry and Sobel kernel weights.
package sobel_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int PIX_W_DEF = 8;
  localparam int MAX_W_DEF = 640;
  localparam int K_EDGE = 1;
  localparam int K_MID = 2;
endpackage

// File: rtl/sobel_stream_if.sv
// sobel_stream_if: frame control plus input/output pixel streams of sobel_stream.
interface sobel_stream_if #(parameter int PIX_W = sobel_pkg::PIX_W_DEF);
  logic start;
  logic [15:0] W, H;
  logic in_valid, in_ready;
  logic [PIX_W-1:0] in_data;
  logic out_valid, out_ready;
  logic [PIX_W-1:0] out_data;
  logic out_last, busy, done, err;
  modport master (
    output start, W, H, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_last, busy, done, err
  );
  modport slave (
    input start, W, H, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, err
  );
endinterface

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: single-port line RAM, synchronous read (old data) with optional write.
module sobel_line_buf #(
  parameter int DW = 8,
  parameter int DEPTH = 640,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= d;
      q <= mem[addr];
    end
endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge magnitude over a raster frame.
// Define SOBEL_THRESH_EN to add the thresh port and binarise the output.
module sobel_stream import sobel_pkg::*; #(
  parameter int PIX_W = PIX_W_DEF,
  parameter int MAX_W = MAX_W_DEF
) (
  input logic clk,
  input logic rstn,
`ifdef SOBEL_THRESH_EN
  input logic [PIX_W-1:0] thresh,
`endif
  sobel_stream_if.slave bus
);
  localparam int GW = PIX_W + 4;
  localparam int AW = $clog2(MAX_W);
  localparam logic signed [GW-1:0] KE = GW'(K_EDGE);
  localparam logic signed [GW-1:0] KM = GW'(K_MID);
  localparam logic [GW-1:0] SAT = GW'((1 << PIX_W) - 1);
  state_t state;
  logic [15:0] w_q, h_q, x, y;
  logic in_done, stall, accept, cfg_ok, x_end, y_end;
  logic s1_v, s1_out, s1_last, s1_sel, s2_v, s2_last;
  logic [PIX_W-1:0] s1_px, q0, q1, mag, res;
  logic [PIX_W-1:0] win [3][3];
  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0] ax, ay, sum;
  logic out_valid, out_last, busy, done, err;
  logic [PIX_W-1:0] out_data;
  assign stall = out_valid && !bus.out_ready;
  assign bus.in_ready = (state == RUN) && !in_done && !stall;
  assign accept = bus.in_valid && bus.in_ready;
  assign cfg_ok = bus.W >= 16'd3 && bus.W <= 16'(MAX_W) && bus.H >= 16'd3;
  assign x_end = x == w_q - 16'd1;
  assign y_end = y == h_q - 16'd1;
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_last = out_last;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.err = err;
  always_ff @(posedge clk)
    if (rstn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      x <= '0;
      y <= '0;
      in_done <= 1'b0;
      w_q <= '0;
      h_q <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        x <= x_end ? 16'd0 : x + 16'd1;
        y <= x_end ? y + 16'd1 : y;
        in_done <= x_end && y_end;
      end
      case (state)
        IDLE:
          if (bus.start) begin
            if (cfg_ok) begin
              state <= RUN;
              busy <= 1'b1;
              w_q <= bus.W;
              h_q <= bus.H;
              x <= '0;
              y <= '0;
              in_done <= 1'b0;
            end else err <= 1'b1;
          end
        RUN:
          if (out_valid && bus.out_ready && out_last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  // Rows alternate between the two buffers: the one holding row y-2 is read
  // before being overwritten with row y, the other still holds row y-1.
  sobel_line_buf #(.DW(PIX_W), .DEPTH(MAX_W), .AW(AW)) lb0 (
    .clk(clk), .en(accept), .we(accept && !y[0]), .addr(x[AW-1:0]), .d(bus.in_data), .q(q0)
  );
  sobel_line_buf #(.DW(PIX_W), .DEPTH(MAX_W), .AW(AW)) lb1 (
    .clk(clk), .en(accept), .we(accept && y[0]), .addr(x[AW-1:0]), .d(bus.in_data), .q(q1)
  );
  always_ff @(posedge clk)
    if (rstn) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (!stall) begin
      s1_v <= accept;
      s1_px <= bus.in_data;
      s1_out <= x >= 16'd2 && y >= 16'd2;
      s1_last <= x_end && y_end;
      s1_sel <= y[0];
      s2_v <= s1_v && s1_out;
      s2_last <= s1_last;
      out_valid <= s2_v;
      out_last <= s2_v && s2_last;
      out_data <= res;
    end
  always_ff @(posedge clk)
    if (!stall && s1_v) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= s1_sel ? q1 : q0;
      win[1][2] <= s1_sel ? q0 : q1;
      win[2][2] <= s1_px;
    end
  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign p[i][j] = $signed({4'b0, win[i][j]});
    end
  end
  assign gx = KE * (p[0][2] - p[0][0]) + KM * (p[1][2] - p[1][0]) + KE * (p[2][2] - p[2][0]);
  assign gy = KE * (p[2][0] - p[0][0]) + KM * (p[2][1] - p[0][1]) + KE * (p[2][2] - p[0][2]);
  assign ax = gx[GW-1] ? -gx : gx;
  assign ay = gy[GW-1] ? -gy : gy;
  assign sum = ax + ay;
  assign mag = sum > SAT ? '1 : sum[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
  assign res = mag >= thresh ? '1 : '0;
`else
  assign res = mag;
`endif
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed frame vectors with hand-computed Sobel outputs.
module tb_sobel_stream;
  typedef struct {
    int w;
    int h;
    int pat;
    int stall_at;
    int n;
    int exp[12];
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[5];
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh = 8'd128;
`endif
  sobel_stream_if #(.PIX_W(8)) bus ();
  sobel_stream #(.PIX_W(8), .MAX_W(640)) dut (
    .clk(clk),
    .rstn(rstn),
`ifdef SOBEL_THRESH_EN
    .thresh(thresh),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int pat, input int x, input int y);
    case (pat)
      0: return 8'd100;
      1: return x >= 3 ? 8'd255 : 8'd0;
      2: return y >= 3 ? 8'd50 : 8'd0;
      3: return 8'(200 - 10 * x - 20 * y);
      default: return 8'd250;
    endcase
  endfunction

  function automatic int expect_of(input int e);
`ifdef SOBEL_THRESH_EN
    return e >= int'(thresh) ? 255 : 0;
`else
    return e;
`endif
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".out_valid"}, int'(bus.out_valid), 0);
    chk({tag, ".out_last"}, int'(bus.out_last), 0);
    chk({tag, ".out_data"}, int'(bus.out_data), 0);
    chk({tag, ".busy"}, int'(bus.busy), 0);
    chk({tag, ".done"}, int'(bus.done), 0);
    chk({tag, ".err"}, int'(bus.err), 0);
    chk({tag, ".in_ready"}, int'(bus.in_ready), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int idx = 0;
    int nout = 0;
    int cyc = 0;
    int stall_left = 5;
    int acc_edge = -1;
    bit seen = 0;
    bit fin = 0;
    bus.W = 16'(v.w);
    bus.H = 16'(v.h);
    bus.start = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.W = 16'd3;
    bus.H = 16'd3;
    chk("busy_after_start", int'(bus.busy), 1);
    while (!fin && cyc < 500) begin
      bus.start = (cyc == 4);
      bus.in_valid = idx < v.w * v.h;
      bus.in_data = pix(v.pat, idx % v.w, idx / v.w);
      bus.out_ready = !(bus.out_valid && nout == v.stall_at && stall_left > 0);
      #1;
      if (!bus.out_ready) begin
        stall_left--;
        chk("stall_in_ready", int'(bus.in_ready), 0);
        chk("stall_data", int'(bus.out_data), expect_of(v.exp[nout]));
        chk("stall_last", int'(bus.out_last), 0);
      end
      if (bus.out_valid && !seen) begin
        seen = 1;
        chk("latency", cyc, acc_edge + 2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (nout < v.n) begin
          chk("data", int'(bus.out_data), expect_of(v.exp[nout]));
          chk("last", int'(bus.out_last), int'(nout == v.n - 1));
        end else chk("extra_output", nout + 1, v.n);
        nout++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (idx == 2 * v.w + 2) acc_edge = cyc + 1;
        idx++;
      end
      if (bus.done) begin
        fin = 1;
        chk("count", nout, v.n);
      end
      tick();
      cyc++;
    end
    chk("done_seen", int'(fin), 1);
    chk("done_pulse", int'(bus.done), 0);
    chk("busy_end", int'(bus.busy), 0);
  endtask

  initial begin
    int k;
    int guard;
    bus.start = 1'b0;
    bus.W = '0;
    bus.H = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    vecs[0] = '{5, 5, 0, -1, 9, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{6, 4, 1, -1, 8, '{0, 255, 255, 0, 0, 255, 255, 0, 0, 0, 0, 0}};
    vecs[2] = '{6, 4, 1, 1, 8, '{0, 255, 255, 0, 0, 255, 255, 0, 0, 0, 0, 0}};
    vecs[3] = '{5, 6, 2, -1, 12, '{0, 0, 0, 200, 200, 200, 200, 200, 200, 0, 0, 0}};
    vecs[4] = '{5, 5, 3, -1, 9, '{240, 240, 240, 240, 240, 240, 240, 240, 240, 0, 0, 0}};
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    chk_reset("reset");
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
`ifdef SOBEL_THRESH_EN
    thresh = 8'd255;
    run_vec(vecs[1]);
    thresh = 8'd128;
`endif
    bus.W = 16'd2;
    bus.H = 16'd10;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("bad_cfg.err", int'(bus.err), 1);
    chk("bad_cfg.busy", int'(bus.busy), 0);
    chk("bad_cfg.in_ready", int'(bus.in_ready), 0);
    repeat (3) tick();
    chk("bad_cfg.in_ready_later", int'(bus.in_ready), 0);
    chk("bad_cfg.err_sticky", int'(bus.err), 1);
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    chk("err_cleared", int'(bus.err), 0);
    bus.W = 16'd5;
    bus.H = 16'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    guard = 0;
    while (k < 7 && guard < 50) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'd250;
      #1;
      if (bus.in_ready) k++;
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("pre_reset_accepts", k, 7);
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    chk_reset("midframe_reset");
    run_vec(vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
